jpeg_scan_packer: RTL

- N-channel entropy-code merger and byte packer for the MJPEG pipeline.
- Accepts variable-length Huffman codes from NCH component encoders in fixed interleave order per MCU, packs them MSB-first into bytes, and inserts 0x00 after every 0xFF data byte.
- Inserts RSTn restart markers every restart_interval MCUs and passes raw header and marker bytes through unstuffed.
- Sits between the component encoders and the USB/Ethernet byte sink. Output uses a valid/ready handshake over an internal FIFO.

---
 rtl/jpeg_pkg.sv | 12 +
 rtl/byte_fifo.sv | 63 ++++++
 rtl/jpeg_scan_packer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants and FSM encoding for the JPEG scan packer.
package jpeg_pkg;
  localparam logic [7:0] M_FF   = 8'hFF;
  localparam logic [7:0] M_RST0 = 8'hD0;
  localparam logic [7:0] M_EOI  = 8'hD9;
  localparam int ACC_W = 64;
  localparam int CNT_W = 7;

  typedef enum logic [2:0] {
    HDR, SCAN, PAD, MARK_FF, MARK_CODE, EOI_FF, EOI_D9
  } state_e;
endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with a registered output stage; count includes the output register.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    mcnt_q, mcnt_d, count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             pop, load;

  always_comb begin
    pop  = out_valid_q && out_ready;
    // Head only advances into the output register when it is free or draining,
    // which keeps out_data stable under backpressure.
    load = (mcnt_q != '0) && (!out_valid_q || pop);
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = load ? rd_q + 1'b1 : rd_q;
    mcnt_d = mcnt_q + CW'(push) - CW'(load);
    out_valid_d = load ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    out_data_d  = load ? mem_q[rd_q] : out_data_q;
    count_d = mcnt_d + CW'(out_valid_d);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      mcnt_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      mcnt_q      <= mcnt_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
endmodule

// File: rtl/jpeg_scan_packer.sv
// Merges per-channel Huffman codes into an MSB-first byte stream with 0xFF
// stuffing, restart markers and EOI, feeding a byte FIFO.
module jpeg_scan_packer import jpeg_pkg::*; #(
  parameter int NCH        = 3,
  parameter int MAX_LEN    = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            frame_end,
  input  logic [15:0]     restart_interval,
  input  logic            hdr_valid,
  input  logic [7:0]      hdr_byte,
  output logic            hdr_ready,
  input  logic [NCH-1:0]  ch_valid,
  input  logic [NCH*6-1:0]  ch_len,
  input  logic [NCH*32-1:0] ch_data,
  input  logic [NCH-1:0]  ch_last,
  output logic [NCH-1:0]  ch_ready,
  output logic            rst_marker,
  output logic            out_valid,
  output logic [7:0]      out_data,
  input  logic            out_ready
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH+1);
  localparam logic [ACC_W-1:0] ONES = {ACC_W{1'b1}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, code;
  logic [CNT_W-1:0] cnt_q, cnt_d, pad_cnt;
  logic [SW-1:0]    slot_q, slot_d;
  logic [15:0]      mcu_q, mcu_d, mcu_n, ri_q, ri_d;
  logic [2:0]       idx_q, idx_d;
  logic             eoi_q, eoi_d, stuff_q, stuff_d;
  logic             push, rst_marker_c, emit, accept, has1, has2, mark_ok;
  logic [7:0]       push_data;
  logic [FW-1:0]    fifo_cnt;
  logic [5:0]       sel_len;
  logic [31:0]      sel_data;

  assign has1 = fifo_cnt < FW'(FIFO_DEPTH);
  assign has2 = fifo_cnt <= FW'(FIFO_DEPTH-2);
  // Two free slots guarantee room for a stuffed 0x00 behind a 0xFF.
  assign emit    = (cnt_q >= CNT_W'(8)) && has2 && !stuff_q;
  assign mark_ok = has1 && !stuff_q && !emit;
  assign sel_len  = ch_len[6*int'(slot_q) +: 6];
  assign sel_data = ch_data[32*int'(slot_q) +: 32];
  assign ch_ready = (!rst && state_q == SCAN && cnt_q <= CNT_W'(ACC_W-MAX_LEN))
                    ? (NCH'(1) << slot_q) : '0;
  assign accept    = |(ch_valid & ch_ready);
  assign hdr_ready = !rst && state_q == HDR && has1 && !emit && !stuff_q;
  assign rst_marker = rst_marker_c && !rst;

  always_comb begin
    state_d = state_q; acc_d = acc_q; cnt_d = cnt_q; slot_d = slot_q;
    mcu_d = mcu_q; idx_d = idx_q; eoi_d = eoi_q; stuff_d = stuff_q; ri_d = ri_q;
    push = 1'b0; push_data = 8'h00; rst_marker_c = 1'b0; pad_cnt = '0;
    mcu_n = mcu_q + 16'd1;
    code  = ACC_W'(sel_data) & ~(ONES << sel_len);

    if (stuff_q) begin
      push = 1'b1; push_data = 8'h00; stuff_d = 1'b0;
    end else if (emit) begin
      push = 1'b1; push_data = acc_q[ACC_W-1 -: 8];
      acc_d = acc_q << 8; cnt_d = cnt_q - CNT_W'(8);
      stuff_d = (acc_q[ACC_W-1 -: 8] == M_FF);
    end else if (hdr_valid && hdr_ready) begin
      push = 1'b1; push_data = hdr_byte;
    end

    case (state_q)
      HDR: if (frame_start) begin
        state_d = SCAN; slot_d = '0; mcu_d = '0; idx_d = '0; eoi_d = 1'b0;
        acc_d = '0; cnt_d = '0; ri_d = restart_interval;
      end
      SCAN: begin
        if (accept) begin
          // New code lands directly below the bits already held (after any pop).
          acc_d = acc_d | (code << (CNT_W'(ACC_W) - cnt_d - CNT_W'(sel_len)));
          cnt_d = cnt_d + CNT_W'(sel_len);
          if (ch_last[slot_q]) begin
            if (slot_q == SW'(NCH-1)) begin
              slot_d = '0;
              if (ri_q != '0 && mcu_n == ri_q) begin
                mcu_d = '0; state_d = PAD;
              end else mcu_d = mcu_n;
            end else slot_d = slot_q + 1'b1;
          end
        end
        if (frame_end) begin
          state_d = PAD; eoi_d = 1'b1; slot_d = '0;
        end
      end
      PAD: begin
        if (cnt_d[2:0] != 3'd0) begin
          pad_cnt = {cnt_d[CNT_W-1:3] + 4'd1, 3'b000};
          acc_d = acc_d | ((ONES >> cnt_d) & ~(ONES >> pad_cnt));
          cnt_d = pad_cnt;
        end else if (cnt_q == '0) state_d = eoi_q ? EOI_FF : MARK_FF;
      end
      MARK_FF: if (mark_ok) begin
        push = 1'b1; push_data = M_FF; state_d = MARK_CODE;
      end
      MARK_CODE: if (mark_ok) begin
        push = 1'b1; push_data = M_RST0 | {5'd0, idx_q};
        idx_d = idx_q + 3'd1; rst_marker_c = 1'b1; state_d = SCAN;
      end
      EOI_FF: if (mark_ok) begin
        push = 1'b1; push_data = M_FF; state_d = EOI_D9;
      end
      EOI_D9: if (mark_ok) begin
        push = 1'b1; push_data = M_EOI; eoi_d = 1'b0; state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR; acc_q <= '0; cnt_q <= '0; slot_q <= '0; mcu_q <= '0;
      idx_q <= '0; eoi_q <= 1'b0; stuff_q <= 1'b0; ri_q <= '0;
    end else begin
      state_q <= state_d; acc_q <= acc_d; cnt_q <= cnt_d; slot_q <= slot_d;
      mcu_q <= mcu_d; idx_q <= idx_d; eoi_q <= eoi_d; stuff_q <= stuff_d;
      ri_q <= ri_d;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (fifo_cnt)
  );
endmodule
